dbus_uart_tx: RTL and testbench

- Memory-mapped UART transmitter. Acts as a responder on the CPU data-memory (dtcm-style) bus, alongside the data TCM and GPIO.
- The top level decodes `sel` as `addr[31:28]==4'hA`.
- The CPU writes bytes into a TX FIFO. A serializer shifts them out on `txd` as 8N1 frames.
- Read data follows the dtcm convention: registered, valid one cycle after the access.

---
 rtl/dbus_uart_tx.sv | 317 +++++++++++++++++++++++++++++++
 tb/tb_dbus_uart_tx.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dbus_uart_tx.sv
// dbus_uart_tx: memory-mapped 8N1 UART transmitter on the CPU data bus.
// A TX FIFO is filled by bus writes and drained by a bit-serial FSM.
// Optional feature macro: DBUS_UART_TX_PARITY_EN adds a parity bit
// (even/odd selected by CTRL bit2) between the data bits and the stop bit.
`timescale 1ns/1ps

module dbus_uart_tx #(
    parameter int CLK_DIV    = 16,
    parameter int FIFO_DEPTH = 8
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        sel,
    input  logic        en,
    input  logic [3:0]  wen,
    input  logic [3:0]  addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        txd,
    output logic        irq
);

    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = AW + 1;
    localparam int BW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam logic [BW-1:0] BAUD_LOAD = BW'(CLK_DIV - 1);
    localparam logic [CW-1:0] CNT_FULL  = CW'(FIFO_DEPTH);

`ifdef DBUS_UART_TX_PARITY_EN
    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } state_t;
`else
    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_START = 3'd1,
        S_DATA  = 3'd2,
        S_STOP  = 3'd4
    } state_t;
`endif

    // Parity of a data byte, optionally inverted for odd parity.
    function automatic logic f_parity(input logic [7:0] d, input logic odd);
        return (^d) ^ odd;
    endfunction

    // Registers
    logic [7:0]    r_mem [FIFO_DEPTH];
    logic [AW-1:0] r_wptr;
    logic [AW-1:0] r_rptr;
    logic [CW-1:0] r_count;
    logic          r_ovf;
    logic          r_tx_en;
    logic          r_irq_en;
    state_t        r_state;
    logic [BW-1:0] r_baud;
    logic [2:0]    r_bit;
    logic [7:0]    r_shift;
    logic          r_txd;
    logic [31:0]   r_rdata;
`ifdef DBUS_UART_TX_PARITY_EN
    logic          r_parity_odd;
    logic          r_par;
    logic          w_par_nx;
`endif

    // Combinational signals
    logic          w_acc_wr;
    logic          w_acc_rd;
    logic          w_wr_tx;
    logic          w_wr_stat;
    logic          w_wr_ctrl;
    logic          w_empty;
    logic          w_full;
    logic          w_busy;
    logic          w_pop;
    logic          w_push_ok;
    logic          w_bit_end;
    logic [7:0]    w_head;
    state_t        w_state_nx;
    logic [BW-1:0] w_baud_nx;
    logic [2:0]    w_bit_nx;
    logic [7:0]    w_shift_nx;
    logic          w_txd_nx;
    logic [3:0]    w_cnt4;
    logic [31:0]   w_status;
    logic [31:0]   w_ctrl;
    logic [31:0]   w_rd_val;
    logic          w_unused;

    assign w_unused  = ^{wdata[31:8], addr[1:0]};

    assign w_acc_wr  = sel & en & (wen != 4'b0000);
    assign w_acc_rd  = sel & en & (wen == 4'b0000);
    assign w_wr_tx   = w_acc_wr & (addr[3:2] == 2'd0) & wen[0];
    assign w_wr_stat = w_acc_wr & (addr[3:2] == 2'd1) & wen[0];
    assign w_wr_ctrl = w_acc_wr & (addr[3:2] == 2'd2) & wen[0];

    assign w_empty   = (r_count == {CW{1'b0}});
    assign w_full    = (r_count == CNT_FULL);
    assign w_busy    = (r_state != S_IDLE);
    assign w_head    = r_mem[r_rptr];
    assign w_push_ok = w_wr_tx & (~w_full | w_pop);
    assign w_bit_end = (r_baud == {BW{1'b0}});

    // FIFO storage: written on every accepted push (no reset needed, pointers gate validity).
    always_ff @(posedge clk) begin
        if (w_push_ok) begin
            r_mem[r_wptr] <= wdata[7:0];
        end
    end

    // FIFO pointers and occupancy; reset discards contents.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wptr  <= {AW{1'b0}};
            r_rptr  <= {AW{1'b0}};
            r_count <= {CW{1'b0}};
        end else begin
            if (w_push_ok) begin
                r_wptr <= r_wptr + 1'b1;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + 1'b1;
            end
            case ({w_push_ok, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Sticky overflow: set on a dropped push, cleared by writing 1 to STATUS bit3.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_ovf <= 1'b0;
        end else if (w_wr_tx && !w_push_ok) begin
            r_ovf <= 1'b1;
        end else if (w_wr_stat && wdata[3]) begin
            r_ovf <= 1'b0;
        end
    end

    // Control register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_tx_en      <= 1'b0;
            r_irq_en     <= 1'b0;
`ifdef DBUS_UART_TX_PARITY_EN
            r_parity_odd <= 1'b0;
`endif
        end else if (w_wr_ctrl) begin
            r_tx_en      <= wdata[0];
            r_irq_en     <= wdata[1];
`ifdef DBUS_UART_TX_PARITY_EN
            r_parity_odd <= wdata[2];
`endif
        end
    end

    // Serializer next-state, counters, pop request and next txd value.
    always_comb begin
        w_state_nx = r_state;
        w_baud_nx  = r_baud;
        w_bit_nx   = r_bit;
        w_shift_nx = r_shift;
        w_pop      = 1'b0;
`ifdef DBUS_UART_TX_PARITY_EN
        w_par_nx   = r_par;
`endif
        case (r_state)
            S_IDLE: begin
                if (r_tx_en && !w_empty) begin
                    w_state_nx = S_START;
                    w_baud_nx  = BAUD_LOAD;
                    w_shift_nx = w_head;
                    w_pop      = 1'b1;
`ifdef DBUS_UART_TX_PARITY_EN
                    w_par_nx   = f_parity(w_head, r_parity_odd);
`endif
                end else begin
                    w_state_nx = S_IDLE;
                end
            end
            S_START: begin
                if (w_bit_end) begin
                    w_state_nx = S_DATA;
                    w_baud_nx  = BAUD_LOAD;
                    w_bit_nx   = 3'd0;
                end else begin
                    w_baud_nx  = r_baud - 1'b1;
                end
            end
            S_DATA: begin
                if (w_bit_end) begin
                    w_baud_nx  = BAUD_LOAD;
                    w_shift_nx = {1'b0, r_shift[7:1]};
                    if (r_bit == 3'd7) begin
`ifdef DBUS_UART_TX_PARITY_EN
                        w_state_nx = S_PARITY;
`else
                        w_state_nx = S_STOP;
`endif
                    end else begin
                        w_bit_nx = r_bit + 3'd1;
                    end
                end else begin
                    w_baud_nx = r_baud - 1'b1;
                end
            end
`ifdef DBUS_UART_TX_PARITY_EN
            S_PARITY: begin
                if (w_bit_end) begin
                    w_state_nx = S_STOP;
                    w_baud_nx  = BAUD_LOAD;
                end else begin
                    w_baud_nx  = r_baud - 1'b1;
                end
            end
`endif
            S_STOP: begin
                if (w_bit_end) begin
                    // Chain the next frame directly so there is no idle gap.
                    if (r_tx_en && !w_empty) begin
                        w_state_nx = S_START;
                        w_baud_nx  = BAUD_LOAD;
                        w_shift_nx = w_head;
                        w_pop      = 1'b1;
`ifdef DBUS_UART_TX_PARITY_EN
                        w_par_nx   = f_parity(w_head, r_parity_odd);
`endif
                    end else begin
                        w_state_nx = S_IDLE;
                    end
                end else begin
                    w_baud_nx = r_baud - 1'b1;
                end
            end
            default: begin
                w_state_nx = S_IDLE;
                w_baud_nx  = {BW{1'b0}};
                w_bit_nx   = 3'd0;
            end
        endcase

        // txd is registered from the next state so it changes on the same edge as the state.
        case (w_state_nx)
            S_START:  w_txd_nx = 1'b0;
            S_DATA:   w_txd_nx = w_shift_nx[0];
`ifdef DBUS_UART_TX_PARITY_EN
            S_PARITY: w_txd_nx = w_par_nx;
`endif
            default:  w_txd_nx = 1'b1;
        endcase
    end

    // Serializer state register; reset drives the line idle-high asynchronously.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
            r_baud  <= {BW{1'b0}};
            r_bit   <= 3'd0;
            r_shift <= 8'h00;
            r_txd   <= 1'b1;
`ifdef DBUS_UART_TX_PARITY_EN
            r_par   <= 1'b0;
`endif
        end else begin
            r_state <= w_state_nx;
            r_baud  <= w_baud_nx;
            r_bit   <= w_bit_nx;
            r_shift <= w_shift_nx;
            r_txd   <= w_txd_nx;
`ifdef DBUS_UART_TX_PARITY_EN
            r_par   <= w_par_nx;
`endif
        end
    end

    assign w_cnt4   = 4'(r_count);
    assign w_status = {20'd0, w_cnt4, 4'd0, r_ovf, w_busy, w_empty, w_full};
`ifdef DBUS_UART_TX_PARITY_EN
    assign w_ctrl   = {29'd0, r_parity_odd, r_irq_en, r_tx_en};
`else
    assign w_ctrl   = {29'd0, 1'b0, r_irq_en, r_tx_en};
`endif

    // Read mux over the register map.
    always_comb begin
        w_rd_val = 32'd0;
        case (addr[3:2])
            2'd1:    w_rd_val = w_status;
            2'd2:    w_rd_val = w_ctrl;
            default: w_rd_val = 32'd0;
        endcase
    end

    // Registered read data, updated only on a read access.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_rdata <= 32'd0;
        end else if (w_acc_rd) begin
            r_rdata <= w_rd_val;
        end
    end

    assign rdata = r_rdata;
    assign txd   = r_txd;
    assign irq   = r_irq_en & w_empty & (r_state == S_IDLE);

endmodule

// File: tb/tb_dbus_uart_tx.sv
// Scoreboard bench for dbus_uart_tx: read expectations and expected serial
// frames are queued by the stimulus and consumed by independent monitors.
`timescale 1ns/1ps

module tb_dbus_uart_tx;

    localparam int CLK_DIV = 4;
    localparam int DEPTH   = 8;
`ifdef DBUS_UART_TX_PARITY_EN
    localparam int NB = 11;
`else
    localparam int NB = 10;
`endif
    localparam int FRAME_CYC = NB * CLK_DIV;

    logic        clk;
    logic        reset_n;
    logic        sel;
    logic        en;
    logic [3:0]  wen;
    logic [3:0]  addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        txd;
    logic        irq;

    int checks = 0;
    int fails  = 0;
    int cyc    = 0;

    logic [31:0]   rd_q[$];
    string         rd_name_q[$];
    logic [31:0]   exp_hold = 32'd0;
    logic [NB-1:0] fr_q[$];
    bit            fr_b2b_q[$];
    logic [31:0]   ctrl_shadow = 32'd0;

    dbus_uart_tx #(.CLK_DIV(CLK_DIV), .FIFO_DEPTH(DEPTH)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .sel     (sel),
        .en      (en),
        .wen     (wen),
        .addr    (addr),
        .wdata   (wdata),
        .rdata   (rdata),
        .txd     (txd),
        .irq     (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Expected line image of a frame: start, 8 data LSB first, [parity], stop.
    function automatic logic [NB-1:0] mk_frame(input logic [7:0] d);
        logic [NB-1:0] f;
        f      = '1;
        f[0]   = 1'b0;
        f[8:1] = d;
`ifdef DBUS_UART_TX_PARITY_EN
        f[9]   = (^d) ^ ctrl_shadow[2];
`endif
        return f;
    endfunction

    task automatic chk(input string n, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", n, got, exp);
        end
    endtask

    // One-cycle bus write; called and returns at a falling edge.
    task automatic bus_write(input logic [3:0] a, input logic [31:0] d);
        sel = 1'b1; en = 1'b1; wen = 4'hF; addr = a; wdata = d;
        @(negedge clk);
        sel = 1'b0; en = 1'b0; wen = 4'h0; addr = 4'h0; wdata = 32'd0;
    endtask

    task automatic bus_read(input logic [3:0] a, input logic [31:0] exp, input string n);
        rd_q.push_back(exp);
        rd_name_q.push_back(n);
        sel = 1'b1; en = 1'b1; wen = 4'h0; addr = a; wdata = 32'd0;
        @(negedge clk);
        sel = 1'b0; en = 1'b0; addr = 4'h0;
    endtask

    task automatic ctrl_wr(input logic [31:0] v);
        ctrl_shadow = v;
        bus_write(4'h8, v);
    endtask

    task automatic tx_byte(input logic [7:0] d, input bit expect_tx, input bit b2b);
        if (expect_tx) begin
            fr_q.push_back(mk_frame(d));
            fr_b2b_q.push_back(b2b);
        end
        bus_write(4'h0, {24'd0, d});
    endtask

    // Read-data monitor: a read must show the queued value one cycle later; otherwise rdata holds.
    always begin
        @(posedge clk);
        if (reset_n === 1'b1) begin
            if (sel && en && (wen == 4'h0)) begin
                #1;
                if (rd_q.size() == 0) begin
                    checks++; fails++;
                    $display("FAIL rd_unexpected: got %h expected no read", rdata);
                end else begin
                    logic [31:0] e;
                    string n;
                    e = rd_q.pop_front();
                    n = rd_name_q.pop_front();
                    chk(n, rdata, e);
                    exp_hold = e;
                end
            end else begin
                #1;
                chk("rdata_hold", rdata, exp_hold);
            end
        end
    end

    // Serial monitor: decode each frame cycle by cycle and compare with the frame queue.
    initial begin
        logic prev;
        int   last_st;
        prev    = 1'b1;
        last_st = 0;
        forever begin
            @(negedge clk);
            if (reset_n !== 1'b1) begin
                prev = 1'b1;
            end else if (prev === 1'b1 && txd === 1'b0) begin
                logic [NB-1:0] got;
                bit            glitch;
                bit            aborted;
                int            st;
                st = cyc; got = '0; glitch = 1'b0; aborted = 1'b0;
                for (int k = 0; k < NB * CLK_DIV && !aborted; k++) begin
                    if (k != 0) @(negedge clk);
                    if (reset_n !== 1'b1) begin
                        aborted = 1'b1;
                    end else if (k % CLK_DIV == 0) begin
                        got[k / CLK_DIV] = txd;
                    end else if (txd !== got[k / CLK_DIV]) begin
                        glitch = 1'b1;
                    end
                end
                if (!aborted) begin
                    if (fr_q.size() == 0) begin
                        checks++; fails++;
                        $display("FAIL frame_unexpected: got %b expected no frame", got);
                    end else begin
                        logic [NB-1:0] e;
                        bit            b2b;
                        e   = fr_q.pop_front();
                        b2b = fr_b2b_q.pop_front();
                        chk("frame_bits", {31'd0, glitch}, 32'd0);
                        chk("frame_image", 32'(got), 32'(e));
                        if (b2b) chk("frame_spacing", 32'(st - last_st), 32'(FRAME_CYC));
                    end
                    last_st = st;
                end
                prev = 1'b1;
            end else begin
                prev = txd;
            end
        end
    end

    initial begin
        int n;
        sel = 1'b0; en = 1'b0; wen = 4'h0; addr = 4'h0; wdata = 32'd0;
        reset_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_txd", {31'd0, txd}, 32'd1);
        chk("rst_irq", {31'd0, irq}, 32'd0);
        chk("rst_rdata", rdata, 32'd0);
        reset_n = 1'b1;
        @(negedge clk);

        // Register map after reset
        bus_read(4'h4, 32'h0000_0002, "status_rst");
        bus_read(4'h8, 32'h0000_0000, "ctrl_rst");
        bus_read(4'h0, 32'h0000_0000, "txdata_rd");
        bus_read(4'hC, 32'h0000_0000, "reserved_rd");
        ctrl_wr(32'h6);
`ifdef DBUS_UART_TX_PARITY_EN
        bus_read(4'h8, 32'h0000_0006, "ctrl_rb");
`else
        bus_read(4'h8, 32'h0000_0002, "ctrl_rb");
`endif
        chk("irq_idle_en", {31'd0, irq}, 32'd1);
        ctrl_wr(32'h1);
        chk("irq_dis", {31'd0, irq}, 32'd0);

        // Single frame 0xA5
        tx_byte(8'hA5, 1'b1, 1'b0);
        repeat (6) @(negedge clk);
        bus_read(4'h4, 32'h0000_0006, "status_busy");
        repeat (FRAME_CYC + 4) @(negedge clk);
        bus_read(4'h4, 32'h0000_0002, "status_done");

        // Two queued bytes, then back-to-back transmission
        ctrl_wr(32'h0);
        tx_byte(8'h55, 1'b1, 1'b0);
        tx_byte(8'h0F, 1'b1, 1'b1);
        bus_read(4'h4, 32'h0000_0200, "status_two");
        ctrl_wr(32'h1);
        repeat (2 * FRAME_CYC + 10) @(negedge clk);
        bus_read(4'h4, 32'h0000_0002, "status_two_done");

        // Overflow while a frame runs with tx_en cleared mid-frame
        tx_byte(8'h3C, 1'b1, 1'b0);
        repeat (3) @(negedge clk);
        ctrl_wr(32'h0);
        for (int i = 0; i < DEPTH + 1; i++) begin
            tx_byte(8'h10 + 8'(i), (i < DEPTH), (i > 0));
        end
        bus_read(4'h4, 32'h0000_080D, "status_ovf_busy");
        repeat (FRAME_CYC + 5) @(negedge clk);
        bus_read(4'h4, 32'h0000_0809, "status_ovf_idle");
        bus_write(4'h4, 32'h0000_0008);
        bus_read(4'h4, 32'h0000_0801, "status_ovf_clr");
        ctrl_wr(32'h1);
        repeat (DEPTH * FRAME_CYC + 10) @(negedge clk);
        bus_read(4'h4, 32'h0000_0002, "status_drained");

        // Interrupt follows empty FIFO and idle FSM
        ctrl_wr(32'h3);
        chk("irq_empty", {31'd0, irq}, 32'd1);
        tx_byte(8'h81, 1'b1, 1'b0);
        chk("irq_after_push", {31'd0, irq}, 32'd0);
        n = 0;
        while (irq !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("irq_latency", 32'(n), 32'(FRAME_CYC + 1));
        ctrl_wr(32'h1);

        // Asynchronous reset in the middle of the data bits
        tx_byte(8'h00, 1'b0, 1'b0);
        repeat (8) @(negedge clk);
        chk("txd_pre_rst", {31'd0, txd}, 32'd0);
        #2;
        reset_n  = 1'b0;
        exp_hold = 32'd0;
        ctrl_shadow = 32'd0;
        #1;
        chk("txd_async_rst", {31'd0, txd}, 32'd1);
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        chk("rdata_after_rst", rdata, 32'd0);
        bus_read(4'h4, 32'h0000_0002, "status_after_rst");
        bus_read(4'h8, 32'h0000_0000, "ctrl_after_rst");

`ifdef DBUS_UART_TX_PARITY_EN
        // Odd parity, two back-to-back 44-cycle frames, then even parity
        ctrl_wr(32'h5);
        tx_byte(8'h07, 1'b1, 1'b0);
        tx_byte(8'h07, 1'b1, 1'b1);
        repeat (2 * FRAME_CYC + 10) @(negedge clk);
        ctrl_wr(32'h1);
        tx_byte(8'h07, 1'b1, 1'b0);
        repeat (FRAME_CYC + 10) @(negedge clk);
`endif

        n = 0;
        while ((fr_q.size() != 0 || rd_q.size() != 0) && n < 1000) begin
            @(negedge clk);
            n++;
        end
        chk("sb_frames_left", 32'(fr_q.size()), 32'd0);
        chk("sb_reads_left", 32'(rd_q.size()), 32'd0);
        repeat (2) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
